vbfs_gather: RTL and testbench
==============================

// Module: vbfs_gather
// PURPOSE
//  Upstream neighbour of the VBFS apply stage; owns the per-node BFS state memory.
//  Gather: consumes incoming messages (dest, sender) and marks unvisited nodes visited+active, parent=sender.
//  Scan: on a barrier message, streams every active node's state to apply, then one barrier token.
//  Takes apply's state write-back (active cleared) on a second memory port.
// PARAMETERS
//  NUM_NODES   16  number of nodes in the state memory
//  ADDR_WIDTH  4   clog2(NUM_NODES); node ids above NUM_NODES-1 are out of range
//  ROOT        0   BFS root node; set visited/active/parent=ROOT during init
// PORTS
//  sys_clk          in   1   clock
//  sys_rst          in   1   synchronous active-high reset
//  msg_valid        in   1   incoming message valid
//  msg_dest         in   32  destination node id
//  msg_sender       in   32  sender node id (candidate parent)
//  msg_round        in   2   round of message
//  msg_barrier      in   1   barrier message (dest/sender ignored)
//  msg_ack          out  1   message consumed this cycle when msg_valid&msg_ack
//  nodeid_out       out  32  node id to apply
//  state_out_parent out  32  stored parent
//  state_out_active out  1   stored active flag
//  state_out_valid  out  1   stored visited flag
//  valid_out        out  1   record/barrier token valid to apply
//  round_out        out  2   round latched from barrier message
//  barrier_out      out  1   barrier token marker
//  apply_ready      in   1   apply accepts when valid_out&apply_ready
//  wb_nodeid        in   32  write-back node id
//  wb_parent        in   32  write-back parent
//  wb_active        in   1   write-back active flag
//  wb_valid         in   1   write-back strobe
//  wb_ack           out  1   write-back accepted (1 outside INIT)
// BEHAVIOUR
//  Memory entry = {visited, active, parent[31:0]}; port A read/write (gather, scan), port B write (wb).
//  Read latency 1 cycle, registered.
//  Reset: all outputs 0, state INIT, address counter 0, skid buffer emptied. Applies mid-operation too:
//    any scan in progress is abandoned.
//  INIT: writes 0 to addr 0..NUM_NODES-1, one per cycle; at ROOT writes {1,1,ROOT}.
//    msg_ack=0, wb_ack=0. After the last address -> GATHER (NUM_NODES cycles after reset release).
//  GATHER: two-phase, at most one message per 2 cycles.
//    RD phase: msg_ack=msg_valid, and the message is captured.
//      Non-barrier message: reads entry at msg_dest[ADDR_WIDTH-1:0] -> WR phase.
//      Barrier message: latch round_out=msg_round, reset scan counter -> SCAN.
//    WR phase: if visited=0, write {1,1,sender}; else no write (first sender wins). Then -> RD.
//    Out-of-range dest: still acked, no write.
//  SCAN: msg_ack=0. Issues reads addr 0..NUM_NODES-1, one per cycle.
//    Returned entries with active=1 enter a 2-entry skid FIFO; inactive entries are dropped.
//    The read issue is suppressed when the FIFO holds 2 entries, or 1 entry with a read in flight.
//    valid_out = FIFO non-empty. nodeid_out = address (zero-extended) and fields from the head entry.
//    The head pops on apply_ready.
//    After the last address is returned and the FIFO drains: emit barrier token
//      (valid_out=1, barrier_out=1, state fields 0, nodeid_out=0), held until apply_ready, then -> GATHER.
//    Outputs stay stable while valid_out&!apply_ready. Throughput 1 record/cycle with apply_ready=1.
//  Write-back: wb_valid&wb_ack writes {1, wb_active, wb_parent} on port B, any state except INIT.
//    Port B wins when both ports write the same address in one cycle.
//    Scan never re-reads an emitted node, so scan/wb conflicts cannot corrupt the stream.
//  No active nodes: scan emits only the barrier token, NUM_NODES+1 cycles after entry at minimum.
// TESTING
//  1 Reset, 16 idle cycles, barrier(round=1) -> exactly one record nodeid=0, parent=0, active=1,
//    valid=1, round=1, then barrier token.
//  2 Messages (dest=5, sender=0) then (dest=5, sender=3), then barrier -> node 5 emitted with parent=0.
//    msg_ack pulses every 2nd cycle.
//  3 Nodes 2, 7, 9 active, apply_ready toggles 1/0 every cycle -> records 2, 7, 9 in order,
//    no drop/duplicate, outputs stable during stall.
//  4 wb (node 7, active=0) during scan, then second barrier -> node 7 absent, others unaffected.
//  5 sys_rst asserted mid-scan after node 2 emitted -> valid_out=0 next cycle,
//    INIT reruns, only ROOT active afterwards.
//  6 msg_dest=40 (out of range) -> acked, no memory change; next scan output unchanged.

Source files
------------

// File: rtl/vbfs_gather.sv
// VBFS gather stage: owns the per-node BFS state memory, marks newly reached nodes from
// incoming messages, and on a barrier streams every active node to the apply stage.
module vbfs_gather #(
    parameter int NUM_NODES  = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int ROOT       = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        msg_valid,
    input  logic [31:0] msg_dest,
    input  logic [31:0] msg_sender,
    input  logic [1:0]  msg_round,
    input  logic        msg_barrier,
    output logic        msg_ack,
    output logic [31:0] nodeid_out,
    output logic [31:0] state_out_parent,
    output logic        state_out_active,
    output logic        state_out_valid,
    output logic        valid_out,
    output logic [1:0]  round_out,
    output logic        barrier_out,
    input  logic        apply_ready,
    input  logic [31:0] wb_nodeid,
    input  logic [31:0] wb_parent,
    input  logic        wb_active,
    input  logic        wb_valid,
    output logic        wb_ack
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_ADDR  = CW'(NUM_NODES - 1);
    localparam logic [CW-1:0] END_ADDR   = CW'(NUM_NODES);
    localparam logic [CW-1:0] ROOT_ADDR  = CW'(ROOT);
    localparam logic [33:0]   ROOT_ENTRY = {2'b11, 32'(ROOT)};

    typedef enum logic [1:0] {
        S_INIT,
        S_GATHER_RD,
        S_GATHER_WR,
        S_SCAN
    } state_t;

    state_t state, state_next;

    // Entry layout: [33] visited, [32] active, [31:0] parent.
    logic [33:0]           mem [NUM_NODES];
    logic [33:0]           rd_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_pend;

    logic [CW-1:0]         addr_cnt;
    logic [ADDR_WIDTH-1:0] cap_dest;
    logic [31:0]           cap_sender;
    logic                  cap_oor;
    logic [1:0]            round_q;

    logic [ADDR_WIDTH-1:0] fifo_addr [2];
    logic [33:0]           fifo_ent  [2];
    logic [1:0]            fifo_cnt;

    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [33:0]           a_wdata;
    logic                  b_we;
    logic                  scan_issue;
    logic                  push;
    logic                  pop;
    logic                  head_valid;
    logic                  scan_done;
    logic [2:0]            occ;

    assign head_valid = (fifo_cnt != 2'd0);
    assign push       = (state == S_SCAN) && rd_pend && rd_data[32];
    assign pop        = (state == S_SCAN) && head_valid && apply_ready;
    assign scan_done  = (state == S_SCAN) && (addr_cnt == END_ADDR) && !rd_pend && !head_valid;

    // Occupancy the FIFO would reach if every outstanding read returned active; a pop in
    // this cycle frees a slot, which is what keeps a full-rate stream going.
    assign occ = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};

    always_comb begin
        state_next = state;
        msg_ack    = 1'b0;
        a_we       = 1'b0;
        a_addr     = '0;
        a_wdata    = '0;
        rd_addr    = '0;
        scan_issue = 1'b0;
        case (state)
            S_INIT: begin
                a_we    = 1'b1;
                a_addr  = addr_cnt[ADDR_WIDTH-1:0];
                a_wdata = (addr_cnt == ROOT_ADDR) ? ROOT_ENTRY : '0;
                if (addr_cnt == LAST_ADDR) state_next = S_GATHER_RD;
            end
            S_GATHER_RD: begin
                msg_ack = msg_valid;
                rd_addr = msg_dest[ADDR_WIDTH-1:0];
                if (msg_valid) state_next = msg_barrier ? S_SCAN : S_GATHER_WR;
            end
            S_GATHER_WR: begin
                a_addr     = cap_dest;
                a_wdata    = {2'b11, cap_sender};
                a_we       = !rd_data[33] && !cap_oor;
                state_next = S_GATHER_RD;
            end
            S_SCAN: begin
                rd_addr    = addr_cnt[ADDR_WIDTH-1:0];
                scan_issue = (addr_cnt != END_ADDR) && (occ <= 3'd1);
                if (scan_done && apply_ready) state_next = S_GATHER_RD;
            end
            default: state_next = S_INIT;
        endcase
    end

    assign wb_ack = (state != S_INIT);
    assign b_we   = wb_valid && wb_ack && (wb_nodeid < 32'(NUM_NODES));

    assign valid_out        = head_valid || scan_done;
    assign barrier_out      = scan_done;
    assign round_out        = round_q;
    assign nodeid_out       = head_valid ? {{(32-ADDR_WIDTH){1'b0}}, fifo_addr[0]} : '0;
    assign state_out_parent = head_valid ? fifo_ent[0][31:0] : '0;
    assign state_out_active = head_valid && fifo_ent[0][32];
    assign state_out_valid  = head_valid && fifo_ent[0][33];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= S_INIT;
            addr_cnt   <= '0;
            rd_pend    <= 1'b0;
            fifo_cnt   <= 2'd0;
            round_q    <= 2'd0;
            cap_dest   <= '0;
            cap_sender <= '0;
            cap_oor    <= 1'b0;
        end else begin
            state   <= state_next;
            rd_pend <= scan_issue;
            case (state)
                S_INIT: addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 1'b1;
                S_GATHER_RD: begin
                    if (msg_valid) begin
                        cap_dest   <= msg_dest[ADDR_WIDTH-1:0];
                        cap_sender <= msg_sender;
                        cap_oor    <= (msg_dest >= 32'(NUM_NODES));
                        if (msg_barrier) begin
                            round_q  <= msg_round;
                            addr_cnt <= '0;
                        end
                    end
                end
                S_SCAN: if (scan_issue) addr_cnt <= addr_cnt + 1'b1;
                default: ;
            endcase
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: ;
            endcase
        end
    end

    // Skid FIFO payload: slot 0 is always the head, slot 1 shifts forward on a pop.
    always_ff @(posedge sys_clk) begin
        rd_addr_q <= rd_addr;
        case ({push, pop})
            2'b10: begin
                if (fifo_cnt == 2'd0) begin
                    fifo_addr[0] <= rd_addr_q;
                    fifo_ent[0]  <= rd_data;
                end else begin
                    fifo_addr[1] <= rd_addr_q;
                    fifo_ent[1]  <= rd_data;
                end
            end
            2'b01: begin
                fifo_addr[0] <= fifo_addr[1];
                fifo_ent[0]  <= fifo_ent[1];
            end
            2'b11: begin
                if (fifo_cnt == 2'd1) begin
                    fifo_addr[0] <= rd_addr_q;
                    fifo_ent[0]  <= rd_data;
                end else begin
                    fifo_addr[0] <= fifo_addr[1];
                    fifo_ent[0]  <= fifo_ent[1];
                    fifo_addr[1] <= rd_addr_q;
                    fifo_ent[1]  <= rd_data;
                end
            end
            default: ;
        endcase
    end

    // Port B is written last so a write-back overrides a gather write to the same node.
    always_ff @(posedge sys_clk) begin
        rd_data <= mem[rd_addr];
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_we) mem[wb_nodeid[ADDR_WIDTH-1:0]] <= {1'b1, wb_active, wb_parent};
    end

endmodule

// File: tb/tb_vbfs_gather.sv
// Directed bench for vbfs_gather: each task drives one scenario and checks the
// records streamed to apply against hand-computed expectations.
module tb_vbfs_gather;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        msg_valid = 1'b0;
    logic [31:0] msg_dest = '0;
    logic [31:0] msg_sender = '0;
    logic [1:0]  msg_round = '0;
    logic        msg_barrier = 1'b0;
    logic        msg_ack;
    logic [31:0] nodeid_out;
    logic [31:0] state_out_parent;
    logic        state_out_active;
    logic        state_out_valid;
    logic        valid_out;
    logic [1:0]  round_out;
    logic        barrier_out;
    logic        apply_ready = 1'b0;
    logic [31:0] wb_nodeid = '0;
    logic [31:0] wb_parent = '0;
    logic        wb_active = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ack;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] rec_id    [32];
    logic [31:0] rec_par   [32];
    logic [3:0]  rec_flags [32];
    int          rec_n;
    int          stab_err;
    bit          tok_seen;
    logic [66:0] tok_snap;
    logic [1:0]  tok_round;

    vbfs_gather #(.NUM_NODES(16), .ADDR_WIDTH(4), .ROOT(0)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .msg_valid(msg_valid), .msg_dest(msg_dest), .msg_sender(msg_sender),
        .msg_round(msg_round), .msg_barrier(msg_barrier), .msg_ack(msg_ack),
        .nodeid_out(nodeid_out), .state_out_parent(state_out_parent),
        .state_out_active(state_out_active), .state_out_valid(state_out_valid),
        .valid_out(valid_out), .round_out(round_out), .barrier_out(barrier_out),
        .apply_ready(apply_ready),
        .wb_nodeid(wb_nodeid), .wb_parent(wb_parent), .wb_active(wb_active),
        .wb_valid(wb_valid), .wb_ack(wb_ack)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one message and hold it until the DUT takes it.
    task automatic send_msg(input logic [31:0] dest, input logic [31:0] sender);
        int waited = 0;
        @(negedge sys_clk);
        msg_valid = 1'b1; msg_barrier = 1'b0; msg_dest = dest; msg_sender = sender;
        #1;
        while (!msg_ack && waited < 20) begin
            @(negedge sys_clk); #1; waited++;
        end
        tests_run++;
        if (msg_ack !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL msg_ack_wait: msg_ack=%b after %0d cycles, required 1", msg_ack, waited);
        end
        @(negedge sys_clk);
        msg_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] node, input logic [31:0] par,
                            input logic act, output logic ack_seen);
        @(negedge sys_clk);
        wb_valid = 1'b1; wb_nodeid = node; wb_parent = par; wb_active = act;
        #1;
        ack_seen = wb_ack;
        @(negedge sys_clk);
        wb_valid = 1'b0;
    endtask

    // Send a barrier and act as apply until the barrier token is accepted.
    task automatic collect_scan(input logic [1:0] round, input bit toggle, input int wb_cycle,
                                input logic [31:0] wb_node, input logic [31:0] wb_par);
        int waited = 0;
        bit done = 1'b0;
        bit stall_prev = 1'b0;
        logic [66:0] snap;
        logic [66:0] snap_prev = '0;
        for (int i = 0; i < 32; i++) begin
            rec_id[i] = '1; rec_par[i] = '1; rec_flags[i] = '1;
        end
        rec_n = 0; stab_err = 0; tok_seen = 1'b0; tok_snap = '1; tok_round = '1;
        @(negedge sys_clk);
        msg_valid = 1'b1; msg_barrier = 1'b1; msg_round = round; msg_dest = '0; msg_sender = '0;
        #1;
        while (!msg_ack && waited < 20) begin
            @(negedge sys_clk); #1; waited++;
        end
        tests_run++;
        if (msg_ack !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL barrier_ack: msg_ack=%b after %0d cycles, required 1", msg_ack, waited);
        end
        @(negedge sys_clk);
        msg_valid = 1'b0; msg_barrier = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc > 0) @(negedge sys_clk);
            apply_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            wb_valid = (cyc == wb_cycle); wb_nodeid = wb_node; wb_parent = wb_par; wb_active = 1'b0;
            #1;
            snap = {nodeid_out, state_out_parent, state_out_active, state_out_valid, barrier_out};
            if (stall_prev && snap !== snap_prev) stab_err++;
            stall_prev = valid_out && !apply_ready;
            snap_prev = snap;
            if (valid_out && apply_ready) begin
                if (barrier_out) begin
                    tok_seen = 1'b1; tok_snap = snap; tok_round = round_out; done = 1'b1;
                end else if (rec_n < 32) begin
                    rec_id[rec_n] = nodeid_out;
                    rec_par[rec_n] = state_out_parent;
                    rec_flags[rec_n] = {state_out_valid, state_out_active, round_out};
                    rec_n++;
                end
            end
        end
        @(negedge sys_clk);
        apply_ready = 1'b0; wb_valid = 1'b0;
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("[TB] FAIL scan_timeout: barrier token seen=%b, required 1 within 200 cycles", tok_seen);
        end
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; msg_valid = 1'b0; wb_valid = 1'b0; apply_ready = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        tests_run++;
        if ({valid_out, barrier_out, msg_ack, wb_ack, round_out, nodeid_out} !== 38'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: valid=%b barrier=%b ack=%b wb_ack=%b round=%0d id=%0d, required all 0",
                     valid_out, barrier_out, msg_ack, wb_ack, round_out, nodeid_out);
        end
        for (int i = 1; i <= 16; i++) begin
            @(negedge sys_clk); #1;
            if (i == 15) begin
                tests_run++;
                if (wb_ack !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL init_len_c15: wb_ack=%b, required 0", wb_ack);
                end
            end
            if (i == 16) begin
                tests_run++;
                if (wb_ack !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL init_len_c16: wb_ack=%b, required 1", wb_ack);
                end
            end
        end
    endtask

    task automatic test_root_scan();
        collect_scan(2'd1, 1'b0, -1, '0, '0);
        tests_run++;
        if (rec_n !== 1 || rec_id[0] !== 32'd0 || rec_par[0] !== 32'd0 || rec_flags[0] !== 4'b1101) begin
            tests_failed++;
            $display("[TB] FAIL root_record: n=%0d id=%0d par=%0d flags=%b, required n=1 id=0 par=0 flags=1101",
                     rec_n, rec_id[0], rec_par[0], rec_flags[0]);
        end
        tests_run++;
        if (tok_snap !== 67'd1 || tok_round !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL root_token: snap=%h round=%0d, required snap=1 round=1", tok_snap, tok_round);
        end
    endtask

    task automatic test_first_sender_wins();
        logic [3:0] acks;
        logic [31:0] exp_id [2] = '{32'd0, 32'd5};
        @(negedge sys_clk);
        msg_valid = 1'b1; msg_barrier = 1'b0; msg_dest = 32'd5; msg_sender = 32'd0;
        #1; acks[3] = msg_ack;
        @(negedge sys_clk);
        msg_sender = 32'd3;
        #1; acks[2] = msg_ack;
        @(negedge sys_clk); #1; acks[1] = msg_ack;
        @(negedge sys_clk);
        msg_valid = 1'b0;
        #1; acks[0] = msg_ack;
        tests_run++;
        if (acks !== 4'b1010) begin
            tests_failed++;
            $display("[TB] FAIL ack_pattern: got %b, required 1010", acks);
        end
        collect_scan(2'd2, 1'b0, -1, '0, '0);
        tests_run++;
        if (rec_n !== 2) begin
            tests_failed++;
            $display("[TB] FAIL fsw_count: got %0d, required 2", rec_n);
        end
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (rec_id[i] !== exp_id[i] || rec_par[i] !== 32'd0 || rec_flags[i] !== 4'b1110) begin
                tests_failed++;
                $display("[TB] FAIL fsw_rec%0d: id=%0d par=%0d flags=%b, required id=%0d par=0 flags=1110",
                         i, rec_id[i], rec_par[i], rec_flags[i], exp_id[i]);
            end
        end
    endtask

    task automatic test_stall_stream();
        logic ack_seen;
        logic [31:0] exp_id  [3] = '{32'd2, 32'd7, 32'd9};
        logic [31:0] exp_par [3] = '{32'd5, 32'd2, 32'd7};
        wb_write(32'd0, 32'd0, 1'b0, ack_seen);
        tests_run++;
        if (ack_seen !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wb_ack: got %b, required 1", ack_seen);
        end
        wb_write(32'd5, 32'd0, 1'b0, ack_seen);
        send_msg(32'd2, 32'd5);
        send_msg(32'd7, 32'd2);
        send_msg(32'd9, 32'd7);
        collect_scan(2'd3, 1'b1, -1, '0, '0);
        tests_run++;
        if (rec_n !== 3 || stab_err !== 0) begin
            tests_failed++;
            $display("[TB] FAIL stall_count: n=%0d unstable=%0d, required n=3 unstable=0", rec_n, stab_err);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rec_id[i] !== exp_id[i] || rec_par[i] !== exp_par[i] || rec_flags[i] !== 4'b1111) begin
                tests_failed++;
                $display("[TB] FAIL stall_rec%0d: id=%0d par=%0d flags=%b, required id=%0d par=%0d flags=1111",
                         i, rec_id[i], rec_par[i], rec_flags[i], exp_id[i], exp_par[i]);
            end
        end
        tests_run++;
        if (tok_snap !== 67'd1 || tok_round !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL stall_token: snap=%h round=%0d, required snap=1 round=3", tok_snap, tok_round);
        end
    endtask

    task automatic test_wb_during_scan();
        // Node 7 is written back inactive before the scan reaches it, so both scans skip it.
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) collect_scan(2'd0, 1'b1, 1, 32'd7, 32'd2);
            else           collect_scan(2'd1, 1'b0, -1, '0, '0);
            tests_run++;
            if (rec_n !== 2 || rec_id[0] !== 32'd2 || rec_par[0] !== 32'd5 ||
                rec_id[1] !== 32'd9 || rec_par[1] !== 32'd7) begin
                tests_failed++;
                $display("[TB] FAIL wb_scan%0d: n=%0d ids=%0d,%0d pars=%0d,%0d, required n=2 ids=2,9 pars=5,7",
                         pass, rec_n, rec_id[0], rec_id[1], rec_par[0], rec_par[1]);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        bit found = 1'b0;
        int waited = 0;
        @(negedge sys_clk);
        msg_valid = 1'b1; msg_barrier = 1'b1; msg_round = 2'd2;
        #1;
        while (!msg_ack && waited < 20) begin
            @(negedge sys_clk); #1; waited++;
        end
        @(negedge sys_clk);
        msg_valid = 1'b0; msg_barrier = 1'b0; apply_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            if (cyc > 0) @(negedge sys_clk);
            #1;
            if (valid_out && !barrier_out && nodeid_out == 32'd2) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("[TB] FAIL midscan_node2: node 2 seen=%b, required 1", found);
        end
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0; apply_ready = 1'b0;
        #1;
        tests_run++;
        if (valid_out !== 1'b0 || wb_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midscan_reset: valid_out=%b wb_ack=%b, required 0 0", valid_out, wb_ack);
        end
        repeat (16) @(negedge sys_clk);
        collect_scan(2'd3, 1'b0, -1, '0, '0);
        tests_run++;
        if (rec_n !== 1 || rec_id[0] !== 32'd0 || rec_par[0] !== 32'd0 || rec_flags[0] !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL reinit_scan: n=%0d id=%0d par=%0d flags=%b, required n=1 id=0 par=0 flags=1111",
                     rec_n, rec_id[0], rec_par[0], rec_flags[0]);
        end
    endtask

    task automatic test_out_of_range();
        send_msg(32'd40, 32'd3);
        collect_scan(2'd0, 1'b0, -1, '0, '0);
        tests_run++;
        if (rec_n !== 1 || rec_id[0] !== 32'd0 || rec_par[0] !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL oor_scan: n=%0d id=%0d par=%0d, required n=1 id=0 par=0",
                     rec_n, rec_id[0], rec_par[0]);
        end
    endtask

    task automatic test_back_to_back_port_priority();
        // Write-back lands in the same cycle as the gather write to node 11.
        @(negedge sys_clk);
        msg_valid = 1'b1; msg_barrier = 1'b0; msg_dest = 32'd11; msg_sender = 32'd0;
        #1;
        tests_run++;
        if (msg_ack !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL prio_ack: msg_ack=%b, required 1", msg_ack);
        end
        @(negedge sys_clk);
        msg_valid = 1'b0;
        wb_valid = 1'b1; wb_nodeid = 32'd11; wb_parent = 32'd9; wb_active = 1'b0;
        @(negedge sys_clk);
        wb_valid = 1'b0;
        send_msg(32'd12, 32'd0);
        collect_scan(2'd1, 1'b0, -1, '0, '0);
        tests_run++;
        if (rec_n !== 2 || rec_id[0] !== 32'd0 || rec_id[1] !== 32'd12 || rec_par[1] !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL prio_scan: n=%0d ids=%0d,%0d par1=%0d, required n=2 ids=0,12 par1=0",
                     rec_n, rec_id[0], rec_id[1], rec_par[1]);
        end
    endtask

    initial begin
        test_reset();
        test_root_scan();
        test_first_sender_wins();
        test_stall_stream();
        test_wb_during_scan();
        test_reset_mid_scan();
        test_out_of_range();
        test_back_to_back_port_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
